// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the two-requester Avalon-MM arbiter.
package avalon_arb_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned BYTES      = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HOLD0 = 2'd1,
        ARB_HOLD1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

endpackage

// File: rtl/arb_resp_fifo.sv
// In-order FIFO of requester IDs for reads awaiting s_readdatavalid.
// Push while full and pop while empty are dropped internally.
module arb_resp_fifo
    import avalon_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  master_id_t i_id,
    output master_id_t o_id,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [DEPTH-1:0] r_mem;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CntW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_id    = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_id;
                r_wr_ptr        <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/avalon_arbiter.sv
// Two-requester Avalon-MM arbiter onto one pipelined slave port.
// Define AVALON_ARB_RR_EN for round-robin contention resolution; default is fixed priority
// (requester 0 wins).
module avalon_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [BYTES-1:0]      m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_waitrequest,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [BYTES-1:0]      m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_waitrequest,
    output logic                  m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic [BYTES-1:0]      s_byteenable,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_WIDTH-1:0] s_writedata,
    input  logic [DATA_WIDTH-1:0] s_readdata,
    input  logic                  s_waitrequest,
    input  logic                  s_readdatavalid,
    output logic                  err_unexpected
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       w_gnt_valid;
    master_id_t w_gnt_id;
    logic       w_sel1;
    logic       w_elig0;
    logic       w_elig1;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    master_id_t w_head;
    logic       r_err;

    // A read is only eligible with FIFO room; a same-cycle pop does not free a slot.
    assign w_elig0 = m0_write | (m0_read & ~w_full);
    assign w_elig1 = m1_write | (m1_read & ~w_full);

    assign w_push = s_read & ~s_waitrequest;
    assign w_pop  = reset & s_readdatavalid & ~w_empty;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_pop & (w_head == 1'b0);
    assign m1_readdatavalid = w_pop & (w_head == 1'b1);
    assign err_unexpected   = r_err;

`ifdef AVALON_ARB_RR_EN
    master_id_t r_last;

    // Remember who last completed a transfer so contention favours the other requester.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last <= 1'b1;
        end else if ((s_read | s_write) & ~s_waitrequest) begin
            r_last <= w_gnt_id;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: lock onto a stalled winner until the slave accepts.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_gnt_valid && s_waitrequest) begin
                    w_state_next = w_gnt_id ? ARB_HOLD1 : ARB_HOLD0;
                end
            end
            ARB_HOLD0, ARB_HOLD1: begin
                if (!s_waitrequest) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    // Outputs: grant decision and request mux; everything gated off while reset is low.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = 1'b0;
        if (reset) begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_elig0 && w_elig1) begin
                        w_gnt_valid = 1'b1;
`ifdef AVALON_ARB_RR_EN
                        w_gnt_id    = ~r_last;
`else
                        w_gnt_id    = 1'b0;
`endif
                    end else if (w_elig0) begin
                        w_gnt_valid = 1'b1;
                        w_gnt_id    = 1'b0;
                    end else if (w_elig1) begin
                        w_gnt_valid = 1'b1;
                        w_gnt_id    = 1'b1;
                    end
                end
                ARB_HOLD0: begin
                    w_gnt_valid = 1'b1;
                    w_gnt_id    = 1'b0;
                end
                ARB_HOLD1: begin
                    w_gnt_valid = 1'b1;
                    w_gnt_id    = 1'b1;
                end
                default: ;
            endcase
        end

        w_sel1         = w_gnt_valid & w_gnt_id;
        s_address      = w_sel1 ? m1_address    : m0_address;
        s_byteenable   = w_sel1 ? m1_byteenable : m0_byteenable;
        s_writedata    = w_sel1 ? m1_writedata  : m0_writedata;
        s_read         = w_gnt_valid & (w_sel1 ? m1_read  : m0_read);
        s_write        = w_gnt_valid & (w_sel1 ? m1_write : m0_write);
        m0_waitrequest = (w_gnt_valid && !w_gnt_id) ? s_waitrequest : 1'b1;
        m1_waitrequest = (w_gnt_valid &&  w_gnt_id) ? s_waitrequest : 1'b1;
    end

    // Sticky flag for a response that no accepted read is waiting on.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (s_readdatavalid && w_empty) begin
            r_err <= 1'b1;
        end
    end

    arb_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_id    (w_gnt_id),
        .o_id    (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_avalon_arbiter.sv
// Self-checking bench for avalon_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level model (grant owner, ID queue, sticky error).
module tb_avalon_arbiter;
    import avalon_arb_pkg::*;

    localparam int MAX = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] m0_address, m1_address, s_address;
    logic [7:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [63:0] m0_writedata, m1_writedata, s_writedata;
    logic [63:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid, err_unexpected;

    always #5 clock = ~clock;

    avalon_arbiter #(
        .ADDR_WIDTH      (16),
        .MAX_OUTSTANDING (MAX)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_readdata      (m0_readdata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_readdata      (m1_readdata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_byteenable     (s_byteenable),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_readdata       (s_readdata),
        .s_waitrequest    (s_waitrequest),
        .s_readdatavalid  (s_readdatavalid),
        .err_unexpected   (err_unexpected)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: locked owner (-1 = none), queue of read owners, last winner.
    int hold;
    int q[$];
    int last;
    bit err_m;

    int          e_g;
    logic        e_sr, e_sw, e_w0, e_w1, e_v0, e_v1;
    logic [15:0] e_sa;
    logic [7:0]  e_sbe;
    logic [63:0] e_swd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hold  = -1;
        q.delete();
        last  = 1;
        err_m = 1'b0;
    endtask

    task automatic model_eval();
        bit el0, el1;
        el0 = m0_write || (m0_read && q.size() < MAX);
        el1 = m1_write || (m1_read && q.size() < MAX);
        if (hold >= 0) e_g = hold;
        else if (el0 && el1) begin
`ifdef AVALON_ARB_RR_EN
            e_g = 1 - last;
`else
            e_g = 0;
`endif
        end
        else if (el0) e_g = 0;
        else if (el1) e_g = 1;
        else e_g = -1;
        e_sr  = (e_g == 0) ? m0_read  : (e_g == 1) ? m1_read  : 1'b0;
        e_sw  = (e_g == 0) ? m0_write : (e_g == 1) ? m1_write : 1'b0;
        e_sa  = (e_g == 1) ? m1_address    : m0_address;
        e_sbe = (e_g == 1) ? m1_byteenable : m0_byteenable;
        e_swd = (e_g == 1) ? m1_writedata  : m0_writedata;
        e_w0  = (e_g == 0) ? s_waitrequest : 1'b1;
        e_w1  = (e_g == 1) ? s_waitrequest : 1'b1;
        e_v0  = s_readdatavalid && q.size() > 0 && q[0] == 0;
        e_v1  = s_readdatavalid && q.size() > 0 && q[0] == 1;
    endtask

    task automatic model_commit();
        if (s_readdatavalid) begin
            if (q.size() > 0) void'(q.pop_front());
            else err_m = 1'b1;
        end
        if (e_sr && !s_waitrequest) q.push_back(e_g);
`ifdef AVALON_ARB_RR_EN
        if ((e_sr || e_sw) && !s_waitrequest) last = e_g;
`endif
        if (hold >= 0) begin
            if (!s_waitrequest) hold = -1;
        end else if (e_g >= 0 && s_waitrequest) begin
            hold = e_g;
        end
    endtask

    // Inputs are applied at posedge+1; outputs are compared at posedge+4.
    task automatic settle();
        #3;
        model_eval();
        check_eq("s_read",       s_read,           e_sr);
        check_eq("s_write",      s_write,          e_sw);
        check_eq("s_address",    s_address,        e_sa);
        check_eq("s_byteenable", s_byteenable,     e_sbe);
        check_eq("s_writedata",  s_writedata,      e_swd);
        check_eq("m0_wait",      m0_waitrequest,   e_w0);
        check_eq("m1_wait",      m1_waitrequest,   e_w1);
        check_eq("m0_rdv",       m0_readdatavalid, e_v0);
        check_eq("m1_rdv",       m1_readdatavalid, e_v1);
        check_eq("m0_rdata",     m0_readdata,      s_readdata);
        check_eq("m1_rdata",     m1_readdata,      s_readdata);
        check_eq("err",          err_unexpected,   err_m);
    endtask

    task automatic advance();
        model_commit();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        m0_address = '0; m0_byteenable = 8'hFF; m0_read = 0; m0_write = 0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = 8'hFF; m1_read = 0; m1_write = 0; m1_writedata = '0;
        s_readdata = '0; s_waitrequest = 0; s_readdatavalid = 0;
    endtask

    // Pulse reset with requests asserted to confirm the outputs are forced asynchronously.
    task automatic do_reset();
        reset = 1'b0;
        m0_write = 1; m1_read = 1; s_readdatavalid = 1;
        #1;
        check_eq("rst_s_read",  s_read,           1'b0);
        check_eq("rst_s_write", s_write,          1'b0);
        check_eq("rst_m0_wait", m0_waitrequest,   1'b1);
        check_eq("rst_m1_wait", m1_waitrequest,   1'b1);
        check_eq("rst_m0_rdv",  m0_readdatavalid, 1'b0);
        check_eq("rst_m1_rdv",  m1_readdatavalid, 1'b0);
        check_eq("rst_err",     err_unexpected,   1'b0);
        check_eq("rst_state",   dut.r_state,      ARB_IDLE);
        @(posedge clock);
        #1;
        idle_inputs();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic rand_master(output logic rd, output logic wr, output logic [15:0] a,
                               output logic [7:0] be, output logic [63:0] wd);
        int r;
        r  = $urandom_range(0, 3);
        rd = (r == 1);
        wr = (r == 2);
        a  = 16'($urandom);
        be = 8'($urandom);
        wd = {$urandom, $urandom};
    endtask

    initial begin
        bit p0, p1;
        idle_inputs();
        do_reset();

        // Single read from m0 and its response.
        m0_read = 1; m0_address = 16'h0010;
        settle();
        check_eq("r33_s_addr", s_address, 16'h0010);
        check_eq("r33_s_read", s_read, 1'b1);
        advance();
        idle_inputs();
        s_readdatavalid = 1; s_readdata = 64'hDEADBEEF_00000001;
        settle();
        check_eq("r33_m0_rdv",  m0_readdatavalid, 1'b1);
        check_eq("r33_m0_data", m0_readdata, 64'hDEADBEEF_00000001);
        check_eq("r33_m1_rdv",  m1_readdatavalid, 1'b0);
        advance();

        // Both write every cycle for four cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m0_write = 1; m0_address = 16'hA000; m0_writedata = 64'(i);
            m1_write = 1; m1_address = 16'hB000; m1_writedata = 64'(100 + i);
            settle();
`ifdef AVALON_ARB_RR_EN
            check_eq("r34_grant", s_address, (i % 2 == 0) ? 16'hA000 : 16'hB000);
            check_eq("r34_m1_wait", m1_waitrequest, (i % 2 == 0) ? 1'b1 : 1'b0);
`else
            check_eq("r34_grant", s_address, 16'hA000);
            check_eq("r34_m1_wait", m1_waitrequest, 1'b1);
`endif
            advance();
        end

        // m1 write stalls three cycles while m0 also requests.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m1_write = 1; m1_address = 16'h1111;
            m0_write = (i > 0); m0_address = 16'h2222;
            s_waitrequest = (i < 3);
            settle();
            check_eq("r35_addr", s_address, 16'h1111);
            check_eq("r35_m0_wait", m0_waitrequest, 1'b1);
            if (i > 0) check_eq("r35_state", dut.r_state, ARB_HOLD1);
            advance();
        end
        m1_write = 0; m0_write = 1; s_waitrequest = 0;
        settle();
        check_eq("r35_m0_next", s_address, 16'h2222);
        check_eq("r35_m0_wait_next", m0_waitrequest, 1'b0);
        advance();

        // Five back-to-back reads into a four-deep response FIFO.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            if (i % 2 == 0) begin m0_read = 1; m0_address = 16'(16'h0300 + i); end
            else begin m1_read = 1; m1_address = 16'(16'h0300 + i); end
            settle();
            if (i < 4) check_eq("r36_accept", (i % 2 == 0) ? m0_waitrequest : m1_waitrequest, 1'b0);
            else begin
                check_eq("r36_5th_stall", m0_waitrequest, 1'b1);
                check_eq("r36_5th_sread", s_read, 1'b0);
            end
            advance();
        end
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            m0_read = (k <= 1); m0_address = 16'h0304;
            s_readdatavalid = 1; s_readdata = 64'(64'h5500 + k);
            settle();
            check_eq("r36_m0_rdv", m0_readdatavalid, (k % 2 == 0) ? 1'b1 : 1'b0);
            check_eq("r36_m1_rdv", m1_readdatavalid, (k % 2 == 1) ? 1'b1 : 1'b0);
            if (k == 0) check_eq("r36_full_pop_stall", m0_waitrequest, 1'b1);
            if (k == 1) check_eq("r36_5th_accept", m0_waitrequest, 1'b0);
            advance();
        end

        // Outstanding read discarded by reset; a later stray response flags an error.
        do_reset();
        m0_read = 1;
        settle();
        advance();
        do_reset();
        s_readdatavalid = 1;
        settle();
        check_eq("r37_m0_rdv", m0_readdatavalid, 1'b0);
        check_eq("r37_m1_rdv", m1_readdatavalid, 1'b0);
        advance();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            settle();
            check_eq("r37_err_sticky", err_unexpected, 1'b1);
            advance();
        end
        do_reset();

        // Randomized traffic; a stalled requester holds its request until accepted.
        p0 = 0; p1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!p0) rand_master(m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
            if (!p1) rand_master(m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
            s_waitrequest   = ($urandom_range(0, 3) == 0);
            s_readdatavalid = ($urandom_range(0, 2) == 0);
            s_readdata      = {$urandom, $urandom};
            settle();
            p0 = (m0_read || m0_write) && e_w0;
            p1 = (m1_read || m1_write) && e_w1;
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
